// File: rtl/data_cache_wb.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_wb
// Purpose  : Direct-mapped write-back / write-allocate byte cache in front of
//            a 32-bit word memory. Optional statistics: DCACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_wb #(
  parameter int LINES       = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int c_IDX_W = $clog2(LINES);
  localparam int c_TAG_W = 6 - c_IDX_W;
  localparam int c_BLK_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [c_TAG_W-1:0] r_tag  [LINES];
  logic [c_BLK_W-1:0] r_data [LINES];
  logic [c_BLK_W-1:0] r_fill;
  logic [5:0]         r_miss_blk;
  logic [7:0]         r_readdata;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_replay;

  logic [c_IDX_W-1:0] w_idx;
  logic [c_TAG_W-1:0] w_tag;
  logic [1:0]         w_off;
  logic [c_IDX_W-1:0] w_midx;
  logic [c_TAG_W-1:0] w_mtag;
  logic               w_req;
  logic               w_rd;
  logic               w_hit;
  logic               w_rd_hit;
  logic               w_wr_hit;
  logic               w_miss;
  logic [7:0]         w_byte;

  assign w_idx    = ADDRESS[2 +: c_IDX_W];
  assign w_tag    = ADDRESS[7 -: c_TAG_W];
  assign w_off    = ADDRESS[1:0];
  // The missing block address is latched so a dropped request cannot corrupt the fill.
  assign w_midx   = r_miss_blk[c_IDX_W-1:0];
  assign w_mtag   = r_miss_blk[5 -: c_TAG_W];
  assign w_req    = READ | WRITE;
  assign w_rd     = READ & ~WRITE;
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_hit = (r_state == S_IDLE) && w_rd && w_hit;
  assign w_wr_hit = (r_state == S_IDLE) && WRITE && w_hit;
  assign w_miss   = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_byte   = r_data[w_idx][{w_off, 3'b000} +: 8];

  assign READDATA      = w_rd_hit ? w_byte : r_readdata;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_WRITEDATA = r_data[w_midx];

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    BUSYWAIT    = 1'b1;
    MEM_ADDRESS = r_miss_blk;
    case (r_state)
      S_IDLE: begin
        BUSYWAIT    = w_req & ~w_hit;
        MEM_ADDRESS = ADDRESS[7:2];
        if (w_req && !w_hit)
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        MEM_ADDRESS = {r_tag[w_midx], w_midx};
        if (!MEM_BUSYWAIT) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (!MEM_BUSYWAIT) w_next = S_UPDATE;
      end
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      r_readdata  <= 8'h00;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_replay    <= 1'b0;
      r_miss_blk  <= 6'h00;
      r_fill      <= '0;
    end else begin
      // Memory strobes come from flops so they never glitch on state decode.
      r_mem_read  <= (w_next == S_FETCH);
      r_mem_write <= (w_next == S_WRITEBACK);
      case (r_state)
        S_IDLE: begin
          r_replay <= 1'b0;
          if (w_rd_hit) r_readdata <= w_byte;
          if (w_wr_hit) begin
            r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
            r_dirty[w_idx]                      <= 1'b1;
          end
          if (w_miss) r_miss_blk <= ADDRESS[7:2];
        end
        S_FETCH: begin
          if (!MEM_BUSYWAIT) r_fill <= MEM_READDATA;
        end
        S_UPDATE: begin
          r_data[w_midx]  <= r_fill;
          r_tag[w_midx]   <= w_mtag;
          r_valid[w_midx] <= 1'b1;
          r_dirty[w_midx] <= 1'b0;
          r_replay        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  // The replayed access right after a fill is not a first-presentation hit.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_hit_cnt  <= 16'h0000;
      r_miss_cnt <= 16'h0000;
    end else if (r_state == S_IDLE && w_req) begin
      if (w_hit && !r_replay && r_hit_cnt != 16'hFFFF)
        r_hit_cnt <= r_hit_cnt + 16'h0001;
      if (!w_hit && r_miss_cnt != 16'hFFFF)
        r_miss_cnt <= r_miss_cnt + 16'h0001;
    end
  end

  assign HIT_COUNT  = r_hit_cnt;
  assign MISS_COUNT = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache_wb.sv
`default_nettype none
// Self-checking bench for data_cache_wb: CPU read scoreboard plus a
// memory-transaction scoreboard against a latency-L memory model.
module tb_data_cache_wb;

  localparam int L = 5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;
`endif

  int checks = 0;
  int errors = 0;
  int n_wr_cyc = 0;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_txn_t;

  logic [7:0] rd_q[$];
  mem_txn_t   mem_q[$];

  data_cache_wb dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory: a transfer finishes L cycles after the request rises (busy for
  // the first L-1, data valid with busy low on the L-th), so a clean miss
  // stalls the CPU for L+2 cycles.
  logic [31:0] mem [64];
  logic [3:0]  mcnt = 4'd0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt != 4'(L - 1));
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) mcnt <= (mcnt == 4'(L - 1)) ? 4'd0 : mcnt + 4'd1;
    else                      mcnt <= 4'd0;
    if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
  end

  // Memory-side scoreboard: each completed transfer must match the queue head.
  always @(negedge CLK) begin
    if (MEM_WRITE) n_wr_cyc++;
    if (RESET && (MEM_READ || MEM_WRITE)) begin
      if (MEM_READ && MEM_WRITE) begin
        checks++; errors++;
        $display("FAIL mem_excl: MEM_READ and MEM_WRITE both high at %0t", $time);
      end
      if (!MEM_BUSYWAIT) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: wr=%0b addr=%h with nothing expected", MEM_WRITE, MEM_ADDRESS);
        end else begin
          mem_txn_t t;
          t = mem_q.pop_front();
          if (MEM_WRITE !== t.wr || MEM_ADDRESS !== t.addr ||
              (t.wr && MEM_WRITEDATA !== t.data)) begin
            errors++;
            $display("FAIL mem_txn: got wr=%0b addr=%h data=%h, expected wr=%0b addr=%h data=%h",
                     MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, t.wr, t.addr, t.data);
          end
        end
      end
    end
  end

  // CPU-side scoreboard: a served read must return the queued byte.
  always @(negedge CLK) begin
    if (RESET && READ && !WRITE && !BUSYWAIT) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: addr=%h data=%h with nothing expected", ADDRESS, READDATA);
      end else begin
        logic [7:0] e;
        e = rd_q.pop_front();
        if (READDATA !== e) begin
          errors++;
          $display("FAIL rd_data: addr=%h got %h expected %h", ADDRESS, READDATA, e);
        end
      end
    end
  end

  task automatic push_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
    mem_txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    mem_q.push_back(t);
  endtask

  // Presents one request, returns the number of stalled cycles, leaves the
  // request asserted just after the serving edge.
  task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] wd, input logic [7:0] exp, output int stall);
    stall = 0;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    if (rd && !wr) rd_q.push_back(exp);
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        @(posedge CLK); #1;
        return;
      end
      stall++;
      @(posedge CLK); #1;
    end
    checks++; errors++;
    $display("FAIL cpu_timeout: addr=%h still busy after %0d cycles", a, stall);
  endtask

  task automatic cpu_idle();
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; cpu_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSYWAIT); end
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", MEM_READ); end
    checks++; if (MEM_WRITE !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", MEM_WRITE); end
    checks++; if (READDATA !== 8'h00) begin errors++; $display("FAIL reset_readdata: got %h expected 00", READDATA); end
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_clean_miss();
    int st; int w0;
    w0 = n_wr_cyc;
    push_mem(1'b0, 6'h05, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h14, 8'h00, 8'hAA, st);
    checks++; if (st !== 7) begin errors++; $display("FAIL clean_miss_stall: got %0d expected 7", st); end
    checks++; if (n_wr_cyc !== w0) begin errors++; $display("FAIL clean_miss_no_wb: got %0d write cycles expected 0", n_wr_cyc - w0); end
    push_mem(1'b0, 6'h00, 32'h0);  // sentinel: must survive a pure hit
    cpu_access(1'b1, 1'b0, 8'h17, 8'h00, 8'hDD, st);
    cpu_idle();
    checks++; if (st !== 0) begin errors++; $display("FAIL hit_stall: got %0d expected 0", st); end
    checks++; if (mem_q.size() !== 1) begin errors++; $display("FAIL hit_no_mem: queue size %0d expected 1", mem_q.size()); end
    void'(mem_q.pop_front());
  endtask

  task automatic test_dirty_evict();
    int st;
    cpu_access(1'b0, 1'b1, 8'h15, 8'h5A, 8'h00, st);
    checks++; if (st !== 0) begin errors++; $display("FAIL write_hit_stall: got %0d expected 0", st); end
    push_mem(1'b1, 6'h05, 32'hDDCC5AAA);
    push_mem(1'b0, 6'h0D, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h34, 8'h00, 8'h11, st);
    cpu_idle();
    checks++; if (st !== 2 * L + 2) begin errors++; $display("FAIL dirty_miss_stall: got %0d expected %0d", st, 2 * L + 2); end
    checks++; if (mem_q.size() !== 0) begin errors++; $display("FAIL dirty_miss_txns: %0d transfers missing", mem_q.size()); end
    checks++; if (mem[5] !== 32'hDDCC5AAA) begin errors++; $display("FAIL wb_mem: got %h expected DDCC5AAA", mem[5]); end
  endtask

  task automatic test_back_to_back();
    int st;
    push_mem(1'b0, 6'h08, 32'h0);
    cpu_access(1'b0, 1'b1, 8'h20, 8'h77, 8'h00, st);
    checks++; if (st !== 7) begin errors++; $display("FAIL write_alloc_stall: got %0d expected 7", st); end
    cpu_access(1'b1, 1'b0, 8'h20, 8'h00, 8'h77, st);
    checks++; if (st !== 0) begin errors++; $display("FAIL alloc_read_stall: got %0d expected 0", st); end
    cpu_access(1'b1, 1'b0, 8'h21, 8'h00, 8'h66, st);
    cpu_access(1'b1, 1'b1, 8'h22, 8'hAB, 8'h00, st);  // both high acts as a write
    cpu_access(1'b1, 1'b0, 8'h22, 8'h00, 8'hAB, st);
    cpu_access(1'b1, 1'b0, 8'h23, 8'h00, 8'h88, st);
    cpu_idle();
    checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL b2b_reads: %0d reads not served", rd_q.size()); end
    checks++; if (mem_q.size() !== 0) begin errors++; $display("FAIL b2b_txns: %0d transfers missing", mem_q.size()); end
  endtask

  task automatic test_reset_mid_fetch();
    int st; bit seen;
    seen = 1'b0;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h08;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      if (MEM_READ) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL fetch_start: MEM_READ never rose"); end
    RESET = 1'b0; cpu_idle();
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL midrst_mem_read: got %b expected 0", MEM_READ); end
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", BUSYWAIT); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    push_mem(1'b0, 6'h05, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h14, 8'h00, 8'hAA, st);
    checks++; if (st !== 7) begin errors++; $display("FAIL post_rst_miss: got stall %0d expected 7", st); end
    push_mem(1'b0, 6'h08, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h20, 8'h00, 8'h55, st);  // dirty 0x77 was discarded
    cpu_idle();
    checks++; if (st !== 7) begin errors++; $display("FAIL discard_dirty: got stall %0d expected 7", st); end
    checks++; if (mem_q.size() !== 0) begin errors++; $display("FAIL midrst_txns: %0d transfers missing", mem_q.size()); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    int st;
    RESET = 1'b0; cpu_idle();
    @(posedge CLK); #1;
    RESET = 1'b1;
    push_mem(1'b0, 6'h05, 32'h0);
    cpu_access(1'b1, 1'b0, 8'h14, 8'h00, 8'hAA, st);
    cpu_access(1'b1, 1'b0, 8'h17, 8'h00, 8'hDD, st);
    cpu_idle();
    @(negedge CLK);
    checks++; if (HIT_COUNT !== 16'd1) begin errors++; $display("FAIL hit_count: got %0d expected 1", HIT_COUNT); end
    checks++; if (MISS_COUNT !== 16'd1) begin errors++; $display("FAIL miss_count: got %0d expected 1", MISS_COUNT); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4{i[7:0]}};
    mem[6'h05] = 32'hDDCCBBAA;
    mem[6'h0D] = 32'h44332211;
    mem[6'h08] = 32'h88776655;
    test_reset();
    test_clean_miss();
    test_dirty_evict();
    test_back_to_back();
    test_reset_mid_fetch();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
